// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
//   Bit-serial unsigned adder/subtractor. One full-adder / full-subtractor cell
//   and a carry/borrow register process one operand bit per clock, LSB first.
//   The per-bit results collect in an internal shift register. The block
//   publishes the word on RESULT only when the run completes.
//
//   Optional feature macro: SERIAL_ADDSUB_OVF_EN
//     defined     -> ovf_o port exists and reports two's-complement overflow
//     not defined -> no ovf_o port and no overflow logic
//
// Ports
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   start_i   in   1      operation request; operands sampled when accepted
//   mode_i    in   1      0 = A+B, 1 = A-B (sampled with start_i)
//   a_i       in   WIDTH  operand A (sampled with start_i)
//   b_i       in   WIDTH  operand B (sampled with start_i)
//   busy_o    out  1      high while the serial run is in progress
//   done_o    out  1      one-cycle pulse; result_o/cout_o valid
//   result_o  out  WIDTH  sum/difference modulo 2^WIDTH, held until next run
//   cout_o    out  1      carry out (add) / borrow out, i.e. A<B (sub)
//   ovf_o     out  1      signed overflow (only with SERIAL_ADDSUB_OVF_EN)
// -----------------------------------------------------------------------------
module serial_addsub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic             mode_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  // Holds the low WIDTH-1 result bits of the run in progress. The final bit
  // joins them on the last edge and the whole word moves to result_q.
  logic [WIDTH-2:0] acc_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf_q;
`else
  // Overflow tracking is not built in this configuration.
`endif

  // Single FA/FS cell acting on the current LSBs of the operand shift regs.
  logic             a_bit;
  logic             b_bit;
  logic             bit_d;
  logic             carry_d;
  logic [WIDTH-1:0] word_d;

  // NOTE: each variable gets a default at the top of always_comb, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    a_bit   = a_sh_q[0];
    b_bit   = b_sh_q[0];
    bit_d   = a_bit ^ b_bit ^ carry_q;
    carry_d = (a_bit & b_bit) | (carry_q & (a_bit ^ b_bit));
    if (mode_q) begin
      // Borrow: the stage must borrow if b exceeds a, or if they are equal
      // and a borrow is already pending.
      carry_d = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & carry_q);
    end
    word_d = {bit_d, acc_q};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      mode_q   <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // FIN behaves like IDLE for acceptance, so back-to-back operations
        // skip the idle cycle.
        S_IDLE, S_FIN: begin
          if (start_i) begin
            a_sh_q  <= a_i;
            b_sh_q  <= b_i;
            mode_q  <= mode_i;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_RUN: begin
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          acc_q   <= word_d[WIDTH-1:1];
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
            result_q <= word_d;
            cout_q   <= carry_d;
`ifdef SERIAL_ADDSUB_OVF_EN
            // Overflow is set when the carry into the MSB differs from the
            // carry out of the MSB.
            ovf_q    <= carry_q ^ carry_d;
`endif
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_FIN;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign cout_o   = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
  assign ovf_o    = ovf_q;
`endif

endmodule
